ser_tx_logic_port: RTL and testbench

// - Parallel-in / serial-out frame transmitter with logic-typed ports.
// - Accepts one DATA_W word per valid/ready handshake.
// - Drives it on txd as: start bit, data LSB-first, optional parity bit, stop bit.
// - Single clock domain; exercises logic ports, enum state and tmrg default triplication.
//

---
 rtl/ser_tx_pkg.sv | 9 +
 rtl/ser_baud_gen.sv | 25 ++
 rtl/ser_tx_logic_port.sv | 103 ++++++++++
 tb/tb_ser_tx_logic_port.sv | 125 ++++++++++++
 4 files changed

// File: rtl/ser_tx_pkg.sv
// Shared types and constants for the serial frame transmitter.
package ser_tx_pkg;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} ser_tx_state_t;

  // Line level while no frame is being sent (also the stop-bit level).
  localparam logic IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/ser_baud_gen.sv
// Bit-period timer: bit_tick is high on the last cycle of every serial bit.
module ser_baud_gen #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic c,
  input  logic rst,
  input  logic clr,
  output logic bit_tick
);

  localparam int CW = $clog2(CLKS_PER_BIT) + 1;
  localparam logic [CW-1:0] LAST_CLK = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] clkCnt;

  // Terminal count marks the last cycle of the current bit; CLKS_PER_BIT=1 ticks every cycle.
  assign bit_tick = (clkCnt == LAST_CLK);

  // Count clocks within a bit, restarting on each bit boundary or when a frame is accepted.
  always_ff @(posedge c) begin
    if (rst || clr || bit_tick) clkCnt <= '0;
    else                        clkCnt <= clkCnt + 1'b1;
  end

endmodule

// File: rtl/ser_tx_logic_port.sv
// Parallel-in / serial-out frame transmitter: start, data LSB-first, optional parity, stop.
module ser_tx_logic_port #(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 4,
  parameter int PARITY_EN    = 1,
  parameter int PARITY_ODD   = 0
) (
  input  logic              c,
  input  logic              rst,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              txd,
  output logic              busy
);

  import ser_tx_pkg::*;

  localparam int BW = $clog2(DATA_W) + 1;
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);

  ser_tx_state_t     state;
  logic [DATA_W-1:0] shreg;
  logic [DATA_W-1:0] shNext;
  logic [BW-1:0]     bitCnt;
  logic              parityBit;
  logic              bitTick;
  logic              accept;

  assign accept = tx_valid && tx_ready;
  assign shNext = shreg >> 1;
  assign busy   = (state != IDLE);

  // Restart the bit timer on acceptance so the start bit is a full bit period long.
  ser_baud_gen #(.CLKS_PER_BIT(CLKS_PER_BIT)) uBaud (
    .c       (c),
    .rst     (rst),
    .clr     (accept),
    .bit_tick(bitTick)
  );

  // Frame FSM with registered line and ready outputs; each state lasts one bit period.
  always_ff @(posedge c) begin
    if (rst) begin
      state     <= IDLE;
      txd       <= IDLE_LEVEL;
      tx_ready  <= 1'b1;
      shreg     <= '0;
      bitCnt    <= '0;
      parityBit <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          txd <= IDLE_LEVEL;
          if (accept) begin
            state     <= START;
            txd       <= 1'b0;
            tx_ready  <= 1'b0;
            shreg     <= tx_data;
            bitCnt    <= '0;
            // Parity is fixed from the latched word, so later tx_data changes cannot affect it.
            parityBit <= (^tx_data) ^ 1'(PARITY_ODD);
          end
        end
        START: if (bitTick) begin
          state  <= DATA;
          txd    <= shreg[0];
          bitCnt <= '0;
        end
        DATA: if (bitTick) begin
          if (bitCnt == LAST_BIT) begin
            if (PARITY_EN != 0) begin
              state <= PARITY;
              txd   <= parityBit;
            end else begin
              state <= STOP;
              txd   <= IDLE_LEVEL;
            end
          end else begin
            shreg  <= shNext;
            txd    <= shNext[0];
            bitCnt <= bitCnt + 1'b1;
          end
        end
        PARITY: if (bitTick) begin
          state <= STOP;
          txd   <= IDLE_LEVEL;
        end
        STOP: if (bitTick) begin
          state    <= IDLE;
          txd      <= IDLE_LEVEL;
          tx_ready <= 1'b1;
        end
        default: begin
          state    <= IDLE;
          txd      <= IDLE_LEVEL;
          tx_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ser_tx_logic_port.sv
// Directed bench: four transmitter configurations sharing one clock.
//   0: 8 bits, 4 clk/bit, even parity   1: odd parity
//   2: no parity                        3: 1 clk/bit, even parity
module tb_ser_tx_logic_port;

  logic       c = 1'b0;
  logic       rst   [4];
  logic       valid [4];
  logic [7:0] data  [4];
  logic       ready [4];
  logic       txd   [4];
  logic       busy  [4];

  int cpbOf   [4] = '{4, 4, 4, 1};
  int parEnOf [4] = '{1, 1, 0, 1};
  int oddOf   [4] = '{0, 1, 0, 0};

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always #5 c = ~c;
  always @(posedge c) cyc <= cyc + 1;

  ser_tx_logic_port #(.DATA_W(8), .CLKS_PER_BIT(4), .PARITY_EN(1), .PARITY_ODD(0)) dut0 (
    .c(c), .rst(rst[0]), .tx_data(data[0]), .tx_valid(valid[0]),
    .tx_ready(ready[0]), .txd(txd[0]), .busy(busy[0]));
  ser_tx_logic_port #(.DATA_W(8), .CLKS_PER_BIT(4), .PARITY_EN(1), .PARITY_ODD(1)) dut1 (
    .c(c), .rst(rst[1]), .tx_data(data[1]), .tx_valid(valid[1]),
    .tx_ready(ready[1]), .txd(txd[1]), .busy(busy[1]));
  ser_tx_logic_port #(.DATA_W(8), .CLKS_PER_BIT(4), .PARITY_EN(0), .PARITY_ODD(0)) dut2 (
    .c(c), .rst(rst[2]), .tx_data(data[2]), .tx_valid(valid[2]),
    .tx_ready(ready[2]), .txd(txd[2]), .busy(busy[2]));
  ser_tx_logic_port #(.DATA_W(8), .CLKS_PER_BIT(1), .PARITY_EN(1), .PARITY_ODD(0)) dut3 (
    .c(c), .rst(rst[3]), .tx_data(data[3]), .tx_valid(valid[3]),
    .tx_ready(ready[3]), .txd(txd[3]), .busy(busy[3]));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic chkIdle(input int d, input string tag);
    chk($sformatf("%s_d%0d_txd", tag, d), 32'(txd[d]), 32'd1);
    chk($sformatf("%s_d%0d_ready", tag, d), 32'(ready[d]), 32'd1);
    chk($sformatf("%s_d%0d_busy", tag, d), 32'(busy[d]), 32'd0);
  endtask

  // Called at a negedge with the DUT idle: present a word for the next posedge.
  task automatic armWord(input int d, input logic [7:0] w);
    data[d]  = w;
    valid[d] = 1'b1;
  endtask

  // Follows a whole frame cycle by cycle, then checks the single idle cycle after it.
  // Without hold, valid drops and tx_data is scrambled to show it is ignored mid-frame.
  task automatic checkFrame(input int d, input logic [7:0] w, input bit hold, output int startCyc);
    bit seq[$];
    seq.push_back(1'b0);
    for (int i = 0; i < 8; i++) seq.push_back(w[i]);
    if (parEnOf[d] != 0) seq.push_back((^w) ^ oddOf[d][0]);
    seq.push_back(1'b1);
    @(negedge c);
    startCyc = cyc;
    if (!hold) begin
      valid[d] = 1'b0;
      data[d]  = ~w;
    end
    for (int j = 0; j < seq.size(); j++) begin
      for (int k = 0; k < cpbOf[d]; k++) begin
        chk($sformatf("d%0d_w%02h_bit%0d_c%0d", d, w, j, k), 32'(txd[d]), 32'(seq[j]));
        chk($sformatf("d%0d_w%02h_ready%0d_c%0d", d, w, j, k), 32'(ready[d]), 32'd0);
        chk($sformatf("d%0d_w%02h_busy%0d_c%0d", d, w, j, k), 32'(busy[d]), 32'd1);
        @(negedge c);
      end
    end
    chkIdle(d, $sformatf("end_w%02h", w));
  endtask

  initial begin
    int s1, s2, sx;
    for (int i = 0; i < 4; i++) begin
      rst[i] = 1'b1; valid[i] = 1'b0; data[i] = 8'h00;
    end
    // Reset held three cycles; idle outputs throughout.
    repeat (3) begin
      @(negedge c);
      for (int i = 0; i < 4; i++) chkIdle(i, "rst");
    end
    for (int i = 0; i < 4; i++) rst[i] = 1'b0;
    @(negedge c);
    for (int i = 0; i < 4; i++) chkIdle(i, "postrst");

    // Single frames: even parity A5, odd parity 00, no parity FF, 1 clk/bit 81.
    armWord(0, 8'hA5); checkFrame(0, 8'hA5, 1'b0, sx);
    armWord(1, 8'h00); checkFrame(1, 8'h00, 1'b0, sx);
    armWord(2, 8'hFF); checkFrame(2, 8'hFF, 1'b0, sx);
    armWord(3, 8'h81); checkFrame(3, 8'h81, 1'b0, sx);

    // Back-to-back with valid held: second start exactly F+1 = 45 cycles later.
    armWord(0, 8'h3C); checkFrame(0, 8'h3C, 1'b1, s1);
    data[0] = 8'hC3;   checkFrame(0, 8'hC3, 1'b0, s2);
    chk("b2b_period", 32'(s2 - s1), 32'd45);

    // Mid-frame reset during data bit 3 (cycles 16..19 after acceptance).
    @(negedge c);
    armWord(0, 8'h96);
    @(negedge c);
    valid[0] = 1'b0;
    repeat (17) @(negedge c);
    chk("mid_bit3_before_rst", 32'(txd[0]), 32'd0);
    rst[0] = 1'b1;
    @(negedge c);
    rst[0] = 1'b0;
    chkIdle(0, "midrst");
    armWord(0, 8'h5A); checkFrame(0, 8'h5A, 1'b0, sx);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
